// File: rtl/mem_access_unit_pkg.sv
// Shared sizes, state encoding and helpers for the memory-stage access unit.
package mem_access_unit_pkg;

  localparam int DSIZE       = 32;
  localparam int ASIZE       = 5;
  localparam int ISIZE       = 16;
  localparam int MAU_TIMEOUT = 16;
  localparam int MAU_CNT_W   = 5;

  typedef enum logic {
    MAU_IDLE = 1'b0,
    MAU_BUSY = 1'b1
  } mau_state_e;

  // Link addresses are narrower than the datapath; widen without sign.
  function automatic logic [DSIZE-1:0] zext_pc(input logic [ISIZE-1:0] pc);
    return {{(DSIZE-ISIZE){1'b0}}, pc};
  endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: async-reset, updated only when load is asserted.
module mem_wb_stage
  import mem_access_unit_pkg::*;
#(
  parameter int DW = DSIZE,
  parameter int AW = ASIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          wen_d,
  input  logic [AW-1:0] waddr_d,
  input  logic [DW-1:0] wdata_d,
  output logic          wen_q,
  output logic [AW-1:0] waddr_q,
  output logic [DW-1:0] wdata_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (load) begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues loads/stores over req/ack, stalls the pipe while busy,
// and drives the MEM/WB register for write-back.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   MAU_IDLE | no access outstanding; non-memory ops pass straight to MEM/WB
//   MAU_BUSY | dm_req held with captured addr/data; waiting for ack/timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = MAU_TIMEOUT,
  parameter int CNT_W   = MAU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic             mem_write_in,
  input  logic             mem_read_in,
  input  logic             mem_to_reg_in,
  input  logic [DSIZE-1:0] result_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] PC_jal_in,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DSIZE-1:0] dm_addr,
  output logic [DSIZE-1:0] dm_wdata,
  input  logic             dm_ack,
  input  logic [DSIZE-1:0] dm_rdata,
  output logic             mem_stall,
  output logic             wb_wen,
  output logic [ASIZE-1:0] wb_waddr,
  output logic [DSIZE-1:0] wb_wdata,
  output logic             dm_err
);

  mau_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cap_wen;
  logic [ASIZE-1:0] cap_waddr;
  logic             cap_m2r;

  logic             access;
  logic             timeout_hit;
  logic             issue, complete, abort;
  logic             wb_load, wb_wen_d;
  logic [ASIZE-1:0] wb_waddr_d;
  logic [DSIZE-1:0] wb_wdata_d;

  assign access      = mem_read_in | mem_write_in;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MAU_IDLE;
    else        state <= state_nxt;
  end

  // Stall drops in the ack/abort cycle so the pipe advances on that edge.
  always_comb begin
    state_nxt  = state;
    mem_stall  = 1'b0;
    issue      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    wb_load    = 1'b0;
    wb_wen_d   = 1'b0;
    wb_waddr_d = wb_waddr;
    wb_wdata_d = wb_wdata;
    case (state)
      MAU_IDLE: begin
        wb_load = 1'b1;
        if (access) begin
          issue     = 1'b1;
          mem_stall = 1'b1;
          state_nxt = MAU_BUSY;
        end else begin
          wb_wen_d   = wen_in;
          wb_waddr_d = waddr_in;
          wb_wdata_d = jal_in ? zext_pc(PC_jal_in) : result_in;
        end
      end
      MAU_BUSY: begin
        if (dm_ack) begin
          complete   = 1'b1;
          state_nxt  = MAU_IDLE;
          wb_load    = 1'b1;
          wb_wen_d   = cap_wen;
          wb_waddr_d = cap_waddr;
          wb_wdata_d = cap_m2r ? dm_rdata : dm_addr;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = MAU_IDLE;
          wb_load   = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      cap_wen   <= 1'b0;
      cap_waddr <= '0;
      cap_m2r   <= 1'b0;
      cnt       <= '0;
      dm_err    <= 1'b0;
    end else begin
      if (issue) begin
        dm_req    <= 1'b1;
        dm_we     <= mem_write_in;
        dm_addr   <= result_in;
        dm_wdata  <= rdata2_in;
        cap_wen   <= wen_in;
        cap_waddr <= waddr_in;
        cap_m2r   <= mem_to_reg_in;
        cnt       <= '0;
      end else if (state == MAU_BUSY && !dm_ack && !timeout_hit) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (complete || abort) dm_req <= 1'b0;
      if (abort)             dm_err <= 1'b1;
    end
  end

  mem_wb_stage #(.DW(DSIZE), .AW(ASIZE)) u_mem_wb (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wb_load),
    .wen_d   (wb_wen_d),
    .waddr_d (wb_waddr_d),
    .wdata_d (wb_wdata_d),
    .wen_q   (wb_wen),
    .waddr_q (wb_waddr),
    .wdata_q (wb_wdata)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver issues ops and plays memory,
// a monitor checks every MEM/WB write-back against expected records.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = MAU_TIMEOUT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wen_in = 1'b0;
  logic [DSIZE-1:0] rdata2_in = '0;
  logic             mem_write_in = 1'b0;
  logic             mem_read_in = 1'b0;
  logic             mem_to_reg_in = 1'b0;
  logic [DSIZE-1:0] result_in = '0;
  logic [ASIZE-1:0] waddr_in = '0;
  logic             jal_in = 1'b0;
  logic [ISIZE-1:0] PC_jal_in = '0;
  logic             dm_req, dm_we;
  logic [DSIZE-1:0] dm_addr, dm_wdata;
  logic             dm_ack = 1'b0;
  logic [DSIZE-1:0] dm_rdata = '0;
  logic             mem_stall, wb_wen, dm_err;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_wdata;

  typedef struct {
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  passed = 0;
  int  total  = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .wen_in(wen_in), .rdata2_in(rdata2_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .result_in(result_in), .waddr_in(waddr_in),
    .jal_in(jal_in), .PC_jal_in(PC_jal_in), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .dm_err(dm_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_nop();
    wen_in = 1'b0; mem_write_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0;
    jal_in = 1'b0; result_in = '0; rdata2_in = '0; waddr_in = '0; PC_jal_in = '0;
  endtask

  // Non-memory op: retires after one cycle, data is link address or ALU result.
  task automatic nonmem(input logic wen, input logic [DSIZE-1:0] res,
                        input logic [ASIZE-1:0] wa, input logic jal,
                        input logic [ISIZE-1:0] pc);
    wb_t e;
    set_nop();
    wen_in = wen; result_in = res; waddr_in = wa; jal_in = jal; PC_jal_in = pc;
    rdata2_in = $urandom;
    mem_to_reg_in = 1'($urandom);
    @(negedge clk);
    chk("stall_nonmem", 32'(mem_stall), 0);
    @(posedge clk); #1;
    if (wen) begin
      e.waddr = wa;
      e.wdata = jal ? {{(DSIZE-ISIZE){1'b0}}, pc} : res;
      exp_q.push_back(e);
    end
  endtask

  // Memory op: lat stalled BUSY cycles, then ack (or no ack -> expect abort).
  task automatic memop(input logic wen, input logic mw, input logic mr, input logic m2r,
                       input logic [DSIZE-1:0] addr, input logic [DSIZE-1:0] wd,
                       input logic [ASIZE-1:0] wa, input int lat, input logic do_ack,
                       input logic [DSIZE-1:0] rd);
    wb_t e;
    int  n;
    set_nop();
    wen_in = wen; mem_write_in = mw; mem_read_in = mr; mem_to_reg_in = m2r;
    result_in = addr; rdata2_in = wd; waddr_in = wa;
    jal_in = 1'($urandom); PC_jal_in = ISIZE'($urandom);
    @(negedge clk);
    chk("stall_issue", 32'(mem_stall), 1);
    chk("req_before_issue", 32'(dm_req), 0);
    @(posedge clk); #1;
    n = do_ack ? lat : TO - 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("req_busy", 32'(dm_req), 1);
      chk("stall_busy", 32'(mem_stall), 1);
      chk("dm_addr", dm_addr, addr);
      chk("dm_we", 32'(dm_we), 32'(mw));
      if (mw) chk("dm_wdata", dm_wdata, wd);
      @(posedge clk); #1;
    end
    if (do_ack) begin
      dm_ack = 1'b1; dm_rdata = rd;
      @(negedge clk);
      chk("req_ack_cycle", 32'(dm_req), 1);
      chk("dm_addr_ack", dm_addr, addr);
      chk("stall_ack_cycle", 32'(mem_stall), 0);
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_rdata = $urandom;
      set_nop();
      chk("req_after_ack", 32'(dm_req), 0);
      if (wen) begin
        e.waddr = wa;
        e.wdata = m2r ? rd : addr;
        exp_q.push_back(e);
      end
    end else begin
      @(negedge clk);
      chk("req_abort_cycle", 32'(dm_req), 1);
      chk("stall_abort_cycle", 32'(mem_stall), 0);
      @(posedge clk); #1;
      set_nop();
      chk("req_after_abort", 32'(dm_req), 0);
      chk("err_after_abort", 32'(dm_err), 1);
      chk("wen_after_abort", 32'(wb_wen), 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_wen) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: got write waddr=%0d data=0x%0h expected none",
                 wb_waddr, wb_wdata);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
        chk("wb_wdata", wb_wdata, e.wdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_nop();
    #3;
    chk("rst_req", 32'(dm_req), 0);
    chk("rst_we", 32'(dm_we), 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_wb_wen", 32'(wb_wen), 0);
    chk("rst_wb_waddr", 32'(wb_waddr), 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_err", 32'(dm_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    nonmem(1'b1, 32'h1234, 5'd5, 1'b0, '0);
    memop(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7, 3, 1'b1, 32'hCAFEF00D);
    memop(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'hA5A5A5A5, 5'd9, 2, 1'b1, 32'h0);
    nonmem(1'b1, 32'hDEAD0000, 5'd31, 1'b1, 16'h0100);
    memop(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd3, 0, 1'b1, 32'h11112222);
    memop(1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 32'h33334444, 5'd4, 0, 1'b1, 32'h0);
    memop(1'b1, 1'b1, 1'b1, 1'b0, 32'h4C, 32'h55556666, 5'd6, 1, 1'b1, 32'h77778888);
    nonmem(1'b0, 32'h9999, 5'd2, 1'b0, '0);

    for (int k = 0; k < 150; k++) begin
      logic mw, mr;
      if ($urandom_range(0, 2) == 0) begin
        nonmem(1'($urandom), $urandom, ASIZE'($urandom), 1'($urandom), ISIZE'($urandom));
      end else begin
        mw = 1'($urandom);
        mr = mw ? 1'($urandom) : 1'b1;
        memop(1'($urandom), mw, mr, 1'($urandom), $urandom, $urandom, ASIZE'($urandom),
              $urandom_range(0, 4), 1'b1, $urandom);
      end
    end

    memop(1'b1, 1'b0, 1'b1, 1'b1, 32'hC0, 32'h0, 5'd8, 0, 1'b0, 32'h0);
    nonmem(1'b1, 32'hABCD, 5'd10, 1'b0, '0);
    chk("err_sticky", 32'(dm_err), 1);
    memop(1'b1, 1'b0, 1'b1, 1'b1, 32'hC4, 32'h0, 5'd11, 1, 1'b1, 32'h0BADBEEF);
    chk("err_sticky_after_load", 32'(dm_err), 1);

    // Reset during BUSY must drop everything without a clock edge.
    set_nop();
    wen_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
    result_in = 32'hE0; waddr_in = 5'd12;
    @(negedge clk);
    @(posedge clk); #1;
    chk("req_before_async_rst", 32'(dm_req), 1);
    #2;
    rst_n = 1'b0;
    set_nop();
    #1;
    chk("arst_req", 32'(dm_req), 0);
    chk("arst_addr", dm_addr, 0);
    chk("arst_wb_wen", 32'(wb_wen), 0);
    chk("arst_wb_wdata", wb_wdata, 0);
    chk("arst_err", 32'(dm_err), 0);
    chk("arst_stall", 32'(mem_stall), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nonmem(1'b1, 32'h5A5A, 5'd13, 1'b0, '0);
    nonmem(1'b0, 32'h0, 5'd0, 1'b0, '0);

    @(negedge clk); #1;
    chk("wb_queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
